// File: rtl/core_run_ctrl_pkg.sv
// core_run_ctrl_pkg: state encoding and counter-width helper for the run controller
package core_run_ctrl_pkg;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    // bits needed to hold the value v
    function automatic int cnt_bits(input int v);
        return $clog2(v + 1);
    endfunction

endpackage

// File: rtl/core_run_ctrl_chan.sv
// core_run_ctrl_chan: per-core run window, early halt and finished status
module core_run_ctrl_chan
    import core_run_ctrl_pkg::*;
#(
    parameter int W_CNT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W_CNT-1:0] tinc,
    input  logic [W_CNT-1:0] tn,
    input  logic [W_CNT-1:0] rk,
    input  logic [W_CNT-1:0] run,
    input  logic             halt,
    input  logic             en,
    input  logic             clr,
    input  logic             go,
    output logic             core_rst,
    output logic             halted,
    output logic             fin
);

    logic [W_CNT:0] stop;
    logic           hset;
    logic           hnext;

    // a halt counts only while released and before the final window cycle
    assign stop  = {1'b0, rk} + {1'b0, run};
    assign hset  = halted || (en && halt && !core_rst && ({1'b0, tinc} < stop));
    assign fin   = hset || ({1'b0, tinc} >= stop);
    assign hnext = clr ? 1'b0 : hset;

    // core reset is low only inside the scheduled window of an active, unhalted core
    always_ff @(posedge clk) begin
        if (!rst) begin
            core_rst <= 1'b1;
            halted   <= 1'b0;
        end else begin
            halted   <= hnext;
            core_rst <= !(go && !hnext && ({1'b0, tn} >= {1'b0, rk}) && ({1'b0, tn} < stop));
        end
    end

endmodule

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: sequences reset hold, staggered release and run windows for N cores
module core_run_ctrl
    import core_run_ctrl_pkg::*;
#(
    parameter int N_CORES     = 1,
    parameter int HOLD_CYCLES = 5,
    parameter int RUN_CYCLES  = 39,
    parameter int STAGGER     = 0,
    parameter int W_CNT       = 16,
    parameter int AUTO_REPEAT = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [N_CORES-1:0] i_halt,
    output logic [N_CORES-1:0] o_core_rst,
    output logic               o_busy,
    output logic               o_done,
    output logic [N_CORES-1:0] o_halted,
    output logic [W_CNT-1:0]   o_run_count
);

    if (cnt_bits(HOLD_CYCLES + (N_CORES - 1) * STAGGER + RUN_CYCLES) > W_CNT) begin : g_width_err
        $error("core_run_ctrl: W_CNT too small for the configured schedule");
    end

    state_t             state, state_n;
    logic [W_CNT-1:0]   t, tn, tinc;
    logic [N_CORES-1:0] fin;
    logic               en, cmpl, rep, clr, go;

    assign en   = (state == S_ACTIVE) && !i_abort;
    assign tinc = (&t) ? t : t + 1'b1;
    assign go   = (state_n == S_ACTIVE);

    for (genvar k = 0; k < N_CORES; k++) begin : g_chan
        core_run_ctrl_chan #(.W_CNT(W_CNT)) u_chan (
            .clk      (i_clk),
            .rst      (i_rst),
            .tinc     (tinc),
            .tn       (tn),
            .rk       (W_CNT'(HOLD_CYCLES + k * STAGGER)),
            .run      (W_CNT'(RUN_CYCLES)),
            .halt     (i_halt[k]),
            .en       (en),
            .clr      (clr),
            .go       (go),
            .core_rst (o_core_rst[k]),
            .halted   (o_halted[k]),
            .fin      (fin[k])
        );
    end

    // completion, restart and next state; abort outranks completion, start only from IDLE
    always_comb begin
        cmpl    = en && (&fin);
        rep     = cmpl && (AUTO_REPEAT != 0);
        clr     = ((state == S_IDLE) && i_start) || rep;
        tn      = clr ? '0 : (state == S_ACTIVE) ? tinc : t;
        state_n = (state == S_IDLE) ? (i_start ? S_ACTIVE : S_IDLE)
                : ((i_abort || (cmpl && !rep)) ? S_IDLE : S_ACTIVE);
    end

    // state, cycle counter and done pulse registers
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state  <= S_IDLE;
            t      <= '0;
            o_done <= 1'b0;
        end else begin
            state  <= state_n;
            t      <= tn;
            o_done <= cmpl;
        end
    end

    assign o_busy      = (state == S_ACTIVE);
    assign o_run_count = t;

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: directed table and sequence checks for core_run_ctrl
module tb_core_run_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b0, start_a = 1'b0, halt_a = 1'b0;
    logic        a_rst, a_busy, a_done, a_halted;
    logic [15:0] a_cnt;

    logic        rst_b = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic [2:0]  halt_b = '0;
    logic [2:0]  b_rst, b_halted;
    logic        b_busy, b_done;
    logic [15:0] b_cnt;

    logic        rst_c = 1'b0, start_c = 1'b0, halt_c = 1'b0;
    logic        c_rst, c_busy, c_done, c_halted;
    logic [15:0] c_cnt;

    core_run_ctrl u_a (
        .i_clk(clk), .i_rst(rst_a), .i_start(start_a), .i_abort(1'b0), .i_halt(halt_a),
        .o_core_rst(a_rst), .o_busy(a_busy), .o_done(a_done), .o_halted(a_halted), .o_run_count(a_cnt)
    );

    core_run_ctrl #(.N_CORES(3), .STAGGER(2)) u_b (
        .i_clk(clk), .i_rst(rst_b), .i_start(start_b), .i_abort(abort_b), .i_halt(halt_b),
        .o_core_rst(b_rst), .o_busy(b_busy), .o_done(b_done), .o_halted(b_halted), .o_run_count(b_cnt)
    );

    core_run_ctrl #(.AUTO_REPEAT(1)) u_c (
        .i_clk(clk), .i_rst(rst_c), .i_start(start_c), .i_abort(1'b0), .i_halt(halt_c),
        .o_core_rst(c_rst), .o_busy(c_busy), .o_done(c_done), .o_halted(c_halted), .o_run_count(c_cnt)
    );

    typedef struct {
        int         e;
        int         sel;
        logic [2:0] rst;
        logic [2:0] hlt;
        logic       busy;
        logic       done;
        int         cnt;
        logic       stc;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   e = 0;

    function automatic vec_t mk(int e_, int sel_, logic [2:0] rst_, logic [2:0] hlt_,
                                logic busy_, logic done_, int cnt_, logic stc_);
        vec_t v;
        v.e = e_; v.sel = sel_; v.rst = rst_; v.hlt = hlt_;
        v.busy = busy_; v.done = done_; v.cnt = cnt_; v.stc = stc_;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic tick_to(input int target);
        while (e < target) tick();
    endtask

    initial begin
        // expected values after edge E<e> counted from the common start edge E0
        tbl.push_back(mk( 0, 0, 3'b001, 3'b000, 1, 0,  0, 0));
        tbl.push_back(mk( 0, 1, 3'b111, 3'b000, 1, 0,  0, 0));
        tbl.push_back(mk( 4, 0, 3'b001, 3'b000, 1, 0,  4, 0));
        tbl.push_back(mk( 5, 0, 3'b000, 3'b000, 1, 0,  5, 0));
        tbl.push_back(mk( 5, 1, 3'b110, 3'b000, 1, 0,  5, 0));
        tbl.push_back(mk( 5, 2, 3'b000, 3'b000, 1, 0,  5, 0));
        tbl.push_back(mk( 7, 1, 3'b100, 3'b000, 1, 0,  7, 0));
        tbl.push_back(mk( 9, 1, 3'b000, 3'b000, 1, 0,  9, 0));
        tbl.push_back(mk(20, 2, 3'b000, 3'b000, 1, 0, 20, 1));
        tbl.push_back(mk(21, 2, 3'b000, 3'b000, 1, 0, 21, 0));
        tbl.push_back(mk(43, 0, 3'b000, 3'b000, 1, 0, 43, 0));
        tbl.push_back(mk(44, 0, 3'b001, 3'b000, 0, 1, 44, 0));
        tbl.push_back(mk(44, 1, 3'b001, 3'b000, 1, 0, 44, 0));
        tbl.push_back(mk(44, 2, 3'b001, 3'b000, 1, 1,  0, 0));
        tbl.push_back(mk(45, 0, 3'b001, 3'b000, 0, 0, 44, 0));
        tbl.push_back(mk(45, 2, 3'b001, 3'b000, 1, 0,  1, 0));
        tbl.push_back(mk(46, 1, 3'b011, 3'b000, 1, 0, 46, 0));
        tbl.push_back(mk(47, 1, 3'b011, 3'b000, 1, 0, 47, 0));
        tbl.push_back(mk(48, 1, 3'b111, 3'b000, 0, 1, 48, 0));
        tbl.push_back(mk(48, 2, 3'b001, 3'b000, 1, 0,  4, 0));
        tbl.push_back(mk(49, 1, 3'b111, 3'b000, 0, 0, 48, 0));
        tbl.push_back(mk(49, 2, 3'b000, 3'b000, 1, 0,  5, 0));
        tbl.push_back(mk(87, 2, 3'b000, 3'b000, 1, 0, 43, 0));
        tbl.push_back(mk(88, 2, 3'b001, 3'b000, 1, 1,  0, 0));

        tick();
        tick();
        chk("reset a rst", a_rst, 1);
        chk("reset a busy", a_busy, 0);
        chk("reset a done", a_done, 0);
        chk("reset a cnt", a_cnt, 0);
        chk("reset b rst", b_rst, 7);
        chk("reset b halted", b_halted, 0);
        chk("reset c busy", c_busy, 0);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        tick();
        start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        e = 0;

        foreach (tbl[i]) begin
            logic [2:0] ar, ah;
            logic       ab, ad;
            int         ac;
            tick_to(tbl[i].e);
            ar = tbl[i].sel == 0 ? {2'b00, a_rst}    : tbl[i].sel == 1 ? b_rst    : {2'b00, c_rst};
            ah = tbl[i].sel == 0 ? {2'b00, a_halted} : tbl[i].sel == 1 ? b_halted : {2'b00, c_halted};
            ab = tbl[i].sel == 0 ? a_busy : tbl[i].sel == 1 ? b_busy : c_busy;
            ad = tbl[i].sel == 0 ? a_done : tbl[i].sel == 1 ? b_done : c_done;
            ac = tbl[i].sel == 0 ? int'(a_cnt) : tbl[i].sel == 1 ? int'(b_cnt) : int'(c_cnt);
            chk($sformatf("tbl[%0d] E%0d dut%0d core_rst", i, tbl[i].e, tbl[i].sel), ar, tbl[i].rst);
            chk($sformatf("tbl[%0d] E%0d dut%0d halted", i, tbl[i].e, tbl[i].sel), ah, tbl[i].hlt);
            chk($sformatf("tbl[%0d] E%0d dut%0d busy", i, tbl[i].e, tbl[i].sel), ab, tbl[i].busy);
            chk($sformatf("tbl[%0d] E%0d dut%0d done", i, tbl[i].e, tbl[i].sel), ad, tbl[i].done);
            chk($sformatf("tbl[%0d] E%0d dut%0d count", i, tbl[i].e, tbl[i].sel), ac, tbl[i].cnt);
            start_c = tbl[i].stc;
        end

        // halt outside window ignored, halt core 1 at E20, halt at scheduled rise ignored
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        e = 0;
        tick_to(2);
        halt_b = 3'b100;
        tick();
        halt_b = 3'b000;
        chk("halt before window halted", b_halted, 0);
        tick_to(19);
        halt_b = 3'b010;
        tick();
        halt_b = 3'b000;
        chk("halt E20 core_rst", b_rst, 3'b010);
        chk("halt E20 halted", b_halted, 3'b010);
        tick_to(43);
        halt_b = 3'b001;
        tick();
        halt_b = 3'b000;
        chk("halt at rise halted", b_halted, 3'b010);
        chk("halt at rise core_rst", b_rst, 3'b011);
        chk("halt run done E44", b_done, 0);
        tick_to(48);
        chk("halt run done E48", b_done, 1);
        chk("halt run busy E48", b_busy, 0);
        chk("halt run halted kept", b_halted, 3'b010);

        // abort at E10 keeps halted, restart at E12 starts from t=0
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        e = 0;
        chk("restart clears halted", b_halted, 0);
        tick_to(7);
        halt_b = 3'b001;
        tick();
        halt_b = 3'b000;
        chk("halt E8 core_rst", b_rst, 3'b101);
        tick_to(9);
        abort_b = 1'b1;
        tick();
        abort_b = 1'b0;
        chk("abort core_rst", b_rst, 3'b111);
        chk("abort busy", b_busy, 0);
        chk("abort done", b_done, 0);
        chk("abort halted kept", b_halted, 3'b001);
        tick();
        chk("abort no done E11", b_done, 0);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        e = 0;
        chk("restart busy", b_busy, 1);
        chk("restart count", b_cnt, 0);
        chk("restart halted", b_halted, 0);
        tick_to(5);
        chk("restart E5 core_rst", b_rst, 3'b110);
        chk("restart E5 count", b_cnt, 5);

        // synchronous reset mid-run with start and halt ignored
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        e = 0;
        tick_to(29);
        chk("pre-reset core_rst", a_rst, 0);
        rst_a = 1'b0; start_a = 1'b1; halt_a = 1'b1;
        tick();
        chk("midreset core_rst", a_rst, 1);
        chk("midreset busy", a_busy, 0);
        chk("midreset count", a_cnt, 0);
        chk("midreset halted", a_halted, 0);
        chk("midreset done", a_done, 0);
        tick();
        chk("start during reset busy", a_busy, 0);
        rst_a = 1'b1; start_a = 1'b0; halt_a = 1'b0;
        tick();
        chk("after reset busy", a_busy, 0);
        chk("after reset count", a_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
